uart_apb_ctrl: RTL and testbench



---
 rtl/uart_apb_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_apb_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_ctrl.sv
// APB register front-end for a UART core: TX/RX byte FIFOs, a TX launch
// sequencer, sticky receive error flags and a level interrupt.
module uart_apb_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        aclk,
    input  logic        areset_n,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_done,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic [2:0]  rx_error,
    output logic        tx_enable,
    output logic        rx_enable,
    output logic [1:0]  baud_rate,
    output logic [1:0]  parity_type,
    output logic        irq
);
    localparam int AW = CW - 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} tx_state_e;

    tx_state_e     state_q, state_d;
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [8:0]    ctrl_q, ctrl_d;
    logic [3:0]    err_q, err_d;
    logic          tx_send_q, tx_send_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          irq_q, irq_d;

    logic          access, wr_acc, rd_acc;
    logic [2:0]    reg_sel;
    logic          tx_full, tx_empty, rx_full, rx_empty, tx_busy;
    logic          tx_push, tx_pop, rx_push_req, rx_push, rx_pop, rx_ovf;
    logic          ctrl_wr, err_wr, slv_err;
    logic [31:0]   status, rd_data;
    logic          unused_bits;

    assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:9]};

    assign access  = PSEL & PENABLE;
    assign wr_acc  = access & PWRITE;
    assign rd_acc  = access & ~PWRITE;
    assign reg_sel = PADDR[4:2];

    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_busy  = (state_q != S_IDLE);

    assign status = {8'd0, 8'(rx_cnt_q), 8'(tx_cnt_q), 3'd0,
                     tx_busy, rx_empty, rx_full, tx_empty, tx_full};

    // Rejected accesses must leave every register untouched.
    always_comb begin
        slv_err = 1'b0;
        case (reg_sel)
            3'd0:       slv_err = PWRITE & tx_full;
            3'd1:       slv_err = PWRITE | rx_empty;
            3'd2:       slv_err = PWRITE;
            3'd3, 3'd4: slv_err = 1'b0;
            default:    slv_err = 1'b1;
        endcase
    end

    always_comb begin
        rd_data = '0;
        if (rd_acc) begin
            case (reg_sel)
                3'd1:    rd_data = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd_ptr_q]};
                3'd2:    rd_data = status;
                3'd3:    rd_data = {23'd0, ctrl_q};
                3'd4:    rd_data = {28'd0, err_q};
                default: rd_data = '0;
            endcase
        end
    end

    assign tx_push     = wr_acc & (reg_sel == 3'd0) & ~tx_full;
    assign rx_pop      = rd_acc & (reg_sel == 3'd1) & ~rx_empty;
    assign ctrl_wr     = wr_acc & (reg_sel == 3'd3);
    assign err_wr      = wr_acc & (reg_sel == 3'd4);
    assign tx_pop      = (state_q == S_SEND);
    assign rx_push_req = rx_done & ctrl_q[1];
    assign rx_push     = rx_push_req & (~rx_full | rx_pop);
    assign rx_ovf      = rx_push_req & rx_full & ~rx_pop;

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q + AW'(tx_push);
        tx_rd_ptr_d = tx_rd_ptr_q + AW'(tx_pop);
        tx_cnt_d    = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_wr_ptr_d = rx_wr_ptr_q + AW'(rx_push);
        rx_rd_ptr_d = rx_rd_ptr_q + AW'(rx_pop);
        rx_cnt_d    = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        ctrl_d      = ctrl_wr ? PWDATA[8:0] : ctrl_q;
        // New error bits are OR-ed after the clear so a same-cycle set wins.
        err_d       = (err_q & ~(err_wr ? PWDATA[3:0] : 4'd0))
                      | {rx_ovf, rx_push_req ? rx_error : 3'd0};
        irq_d       = (ctrl_q[6] & ~rx_empty)
                      | (ctrl_q[7] & tx_empty & (state_q == S_IDLE))
                      | (ctrl_q[8] & (|err_q));
    end

    always_comb begin
        state_d   = state_q;
        tx_send_d = 1'b0;
        tx_data_d = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0] && !tx_empty) begin
                    state_d   = S_SEND;
                    tx_send_d = 1'b1;
                    tx_data_d = tx_mem[tx_rd_ptr_q];
                end
            end
            S_SEND:  state_d = S_WAIT;
            S_WAIT:  if (tx_done) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= S_IDLE;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            ctrl_q      <= '0;
            err_q       <= '0;
            tx_send_q   <= 1'b0;
            tx_data_q   <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            ctrl_q      <= ctrl_d;
            err_q       <= err_d;
            tx_send_q   <= tx_send_d;
            tx_data_q   <= tx_data_d;
            irq_q       <= irq_d;
        end
    end

    // Storage carries no reset; only the pointers and counts define validity.
    always_ff @(posedge aclk) begin
        if (tx_push) tx_mem[tx_wr_ptr_q] <= PWDATA[7:0];
        if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
    end

    assign PRDATA      = rd_data;
    assign PSLVERR     = access & slv_err;
    assign PREADY      = 1'b1;
    assign tx_send     = tx_send_q;
    assign tx_data     = tx_data_q;
    assign irq         = irq_q;
    assign tx_enable   = ctrl_q[0];
    assign rx_enable   = ctrl_q[1];
    assign baud_rate   = ctrl_q[3:2];
    assign parity_type = ctrl_q[5:4];

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Scoreboard bench for uart_apb_ctrl: directed scenarios plus a randomized
// register/RX sequence checked against a queue-based model of the register file.
module tb_uart_apb_ctrl;
    localparam int DEPTH = 8;

    logic        aclk = 1'b0;
    logic        areset_n = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_done = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_done = 1'b0;
    logic [2:0]  rx_error = '0;
    logic        tx_enable, rx_enable;
    logic [1:0]  baud_rate, parity_type;
    logic        irq;

    uart_apb_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_data(tx_data), .tx_send(tx_send), .tx_done(tx_done),
        .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
        .tx_enable(tx_enable), .rx_enable(rx_enable),
        .baud_rate(baud_rate), .parity_type(parity_type), .irq(irq)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge aclk) cyc++;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard queues
    typedef struct { logic [31:0] rd; logic err; } apb_exp_t;
    typedef struct { logic [7:0] data; int gap; } tx_exp_t;
    apb_exp_t apb_exp[$];
    tx_exp_t  tx_exp[$];
    apb_exp_t mon_a;
    tx_exp_t  mon_t;
    int       last_send = 0;

    always @(negedge aclk) begin
        if (PSEL && PENABLE) begin
            if (apb_exp.size() == 0) begin
                check("apb_unexpected", {31'd0, PENABLE}, 32'd0);
            end else begin
                mon_a = apb_exp.pop_front();
                check("prdata", PRDATA, mon_a.rd);
                check("pslverr", {31'd0, PSLVERR}, {31'd0, mon_a.err});
                $display("apb  cyc=%0d wr=%0d sel=%0d prdata=0x%08h pslverr=%0d",
                         cyc, PWRITE, PADDR[4:2], PRDATA, PSLVERR);
            end
        end
        if (tx_send) begin
            if (tx_exp.size() == 0) begin
                check("tx_unexpected_send", {31'd0, tx_send}, 32'd0);
            end else begin
                mon_t = tx_exp.pop_front();
                check("tx_data", {24'd0, tx_data}, {24'd0, mon_t.data});
                if (mon_t.gap > 0) check("tx_gap", cyc - last_send, mon_t.gap);
                $display("tx   cyc=%0d data=0x%02h", cyc, tx_data);
            end
            last_send = cyc;
        end
    end

    // UART line model: tx_done is sampled 20 edges after the tx_send edge.
    logic uart_en = 1'b1;
    logic manual_done = 1'b0;
    int   done_cnt = 0;
    initial begin
        forever begin
            @(negedge aclk);
            tx_done = 1'b0;
            if (manual_done) begin
                tx_done = 1'b1;
                manual_done = 1'b0;
            end else if (!uart_en) begin
                done_cnt = 0;
            end else if (tx_send) begin
                done_cnt = 19;
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) tx_done = 1'b1;
            end
        end
    end

    // Reference model of the register file (valid while the TX sequencer is idle)
    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];
    logic [8:0] m_ctrl = '0;
    logic [3:0] m_err = '0;

    function automatic logic [31:0] m_status();
        int s;
        s = (m_tx.size() == DEPTH ? 1 : 0) + (m_tx.size() == 0 ? 2 : 0)
          + (m_rx.size() == DEPTH ? 4 : 0) + (m_rx.size() == 0 ? 8 : 0)
          + m_tx.size() * 256 + m_rx.size() * 65536;
        return 32'(s);
    endfunction

    function automatic logic m_irq();
        return (m_ctrl[6] && m_rx.size() > 0) || (m_ctrl[7] && m_tx.size() == 0)
            || (m_ctrl[8] && m_err != 4'd0);
    endfunction

    function automatic void model_access(input logic wr, input logic [2:0] sel,
                                         input logic [31:0] wd,
                                         output logic [31:0] rd, output logic err);
        rd = '0;
        err = 1'b0;
        case (sel)
            3'd0: if (wr) begin
                      if (m_tx.size() == DEPTH) err = 1'b1;
                      else m_tx.push_back(wd[7:0]);
                  end
            3'd1: if (wr || m_rx.size() == 0) err = 1'b1;
                  else rd = {24'd0, m_rx.pop_front()};
            3'd2: if (wr) err = 1'b1; else rd = m_status();
            3'd3: if (wr) m_ctrl = wd[8:0]; else rd = {23'd0, m_ctrl};
            3'd4: if (wr) m_err = m_err & ~wd[3:0]; else rd = {28'd0, m_err};
            default: err = 1'b1;
        endcase
    endfunction

    task automatic apb_x(input logic wr, input logic [2:0] sel, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr);
        apb_exp_t e;
        e.rd = erd;
        e.err = eerr;
        apb_exp.push_back(e);
        @(posedge aclk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = $urandom; PADDR[4:2] = sel; PWDATA = wd;
        @(posedge aclk); #1;
        PENABLE = 1'b1;
        @(posedge aclk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb(input logic wr, input logic [2:0] sel, input logic [31:0] wd);
        logic [31:0] rd;
        logic err;
        model_access(wr, sel, wd, rd, err);
        apb_x(wr, sel, wd, rd, err);
    endtask

    task automatic rx_pulse(input logic [7:0] d, input logic [2:0] e);
        if (m_ctrl[1]) begin
            m_err[2:0] = m_err[2:0] | e;
            if (m_rx.size() < DEPTH) m_rx.push_back(d);
            else m_err[3] = 1'b1;
        end
        @(posedge aclk); #1;
        rx_done = 1'b1; rx_data = d; rx_error = e;
        @(posedge aclk); #1;
        rx_done = 1'b0; rx_error = '0;
    endtask

    task automatic check_irq();
        @(posedge aclk); #1;
        check("irq", {31'd0, irq}, {31'd0, m_irq()});
    endtask

    task automatic wait_tx_drain(input int limit);
        int n = 0;
        while (tx_exp.size() != 0 && n < limit) begin
            @(posedge aclk);
            n++;
        end
        check("tx_drain_pending", tx_exp.size(), 0);
        tx_exp.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_outs"}, {22'd0, tx_send, tx_data, irq, PSLVERR,
                                tx_enable, rx_enable, baud_rate, parity_type}, 32'd0);
        check({name, "_prdata"}, PRDATA, 32'd0);
        check({name, "_pready"}, {31'd0, PREADY}, 32'd1);
    endtask

    task automatic do_reset();
        uart_en = 1'b0;
        @(posedge aclk); #1;
        areset_n = 1'b0;
        #2;
        check_reset_outputs("reset_async");
        repeat (2) @(posedge aclk);
        #1 areset_n = 1'b1;
        m_tx.delete(); m_rx.delete(); m_ctrl = '0; m_err = '0;
    endtask

    initial begin
        tx_exp_t t;
        logic [7:0] b;
        int op;

        // Power-on reset
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("reset_por");
        areset_n = 1'b1;
        apb(1'b0, 3'd3, 32'd0);
        apb(1'b0, 3'd2, 32'd0);
        apb(1'b0, 3'd4, 32'd0);
        check_irq();

        // Two frames back to back
        apb(1'b1, 3'd3, 32'h1);
        t.data = 8'h55; t.gap = 0;  tx_exp.push_back(t);
        t.data = 8'hA3; t.gap = 22; tx_exp.push_back(t);
        apb_x(1'b1, 3'd0, 32'h55, 32'd0, 1'b0);
        apb_x(1'b1, 3'd0, 32'hA3, 32'd0, 1'b0);
        wait_tx_drain(200);
        repeat (30) @(posedge aclk);
        apb(1'b0, 3'd2, 32'd0);
        apb(1'b1, 3'd3, 32'h0);

        // TX FIFO overfill with the sequencer disabled
        for (int i = 0; i < 9; i++) apb(1'b1, 3'd0, $urandom);
        apb(1'b0, 3'd2, 32'd0);
        repeat (5) @(posedge aclk);
        do_reset();
        uart_en = 1'b1;

        // Reset while a frame is in WAIT with three bytes still queued
        for (int i = 0; i < 4; i++) apb(1'b1, 3'd0, 32'h80 | ($urandom & 32'h7F));
        t.data = m_tx[0]; t.gap = 0; tx_exp.push_back(t);
        apb(1'b1, 3'd3, 32'h1);
        wait_tx_drain(20);
        repeat (3) @(posedge aclk);
        apb_x(1'b0, 3'd2, 32'd0, 32'h0000_0318, 1'b0);
        do_reset();
        manual_done = 1'b1;
        repeat (30) @(posedge aclk);
        apb(1'b0, 3'd2, 32'd0);
        uart_en = 1'b1;

        // RX with interrupt on non-empty
        apb(1'b1, 3'd3, 32'h42);
        rx_pulse(8'h11, 3'd0);
        rx_pulse(8'h22, 3'd0);
        rx_pulse(8'h33, 3'd0);
        check_irq();
        for (int i = 0; i < 4; i++) begin
            apb(1'b0, 3'd1, 32'd0);
            check_irq();
        end

        // RX overflow and sticky error flags
        apb(1'b1, 3'd3, 32'h2);
        for (int i = 0; i < 9; i++) rx_pulse(8'($urandom), 3'd0);
        apb(1'b0, 3'd4, 32'd0);
        rx_pulse(8'h5A, 3'b010);
        apb(1'b0, 3'd4, 32'd0);
        apb(1'b1, 3'd4, 32'hA);
        apb(1'b0, 3'd4, 32'd0);
        for (int i = 0; i < DEPTH; i++) apb(1'b0, 3'd1, 32'd0);
        apb(1'b0, 3'd2, 32'd0);

        // Randomized register and RX traffic, TX sequencer disabled
        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1: apb(1'b1, 3'd0, $urandom);
                2, 9: rx_pulse(8'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0);
                3:    apb(1'b0, 3'd1, 32'd0);
                4:    apb(1'b0, 3'd2, 32'd0);
                5:    apb(1'b1, 3'd3, ($urandom & ~32'h1) | (($urandom_range(0, 3) != 0) ? 32'h2 : 32'h0));
                6:    apb(1'b1, 3'd4, $urandom);
                7:    apb(1'b0, ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd4, 32'd0);
                default: begin
                    case ($urandom_range(0, 3))
                        0: apb($urandom_range(0, 1) == 1, 3'($urandom_range(5, 7)), $urandom);
                        1: apb(1'b1, 3'd2, $urandom);
                        2: apb(1'b1, 3'd1, $urandom);
                        default: apb(1'b0, 3'd0, 32'd0);
                    endcase
                end
            endcase
            check_irq();
        end

        // Drain whatever the random phase queued for transmit
        for (int i = 0; i < m_tx.size(); i++) begin
            t.data = m_tx[i];
            t.gap = (i == 0) ? 0 : 22;
            tx_exp.push_back(t);
        end
        m_tx.delete();
        apb(1'b1, 3'd3, 32'h1);
        wait_tx_drain(DEPTH * 22 + 60);
        repeat (30) @(posedge aclk);
        apb(1'b0, 3'd2, 32'd0);
        repeat (3) @(posedge aclk);
        check("apb_pending", apb_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
